// File: rtl/systolic_drain.sv
// De-skews the bottom-edge result stream of the systolic array into whole rows and queues them downstream.
// Optional build macro: DRAIN_RELU_EN clamps negative elements to zero before they are queued.
module systolic_drain #(
  parameter int N          = 32,
  parameter int DATA_W     = 16,
  parameter int ROWS       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [0:N-1]                    col_valid,
  input  logic [0:N-1][DATA_W-1:0]        col_data,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [0:N-1][DATA_W-1:0]        row_data,
  output logic [$clog2(ROWS)-1:0]         row_idx,
  output logic                            tile_done,
  output logic                            overflow,
  output logic                            skew_err
);

  localparam int CNT_W = $clog2(ROWS);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]                  state_r;
  logic [CNT_W-1:0]            cnt_r;
  logic                        overflow_r;
  logic                        skew_err_r;

  logic [0:N-1][DATA_W-1:0]    mem_r [FIFO_DEPTH];
  logic [CNT_W-1:0]            tag_r [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr_r;
  logic [AW-1:0]               rd_ptr_r;
  logic [AW:0]                 count_r;

  logic [0:N-1]                al_valid_s;
  logic [0:N-1][DATA_W-1:0]    al_data_s;
  logic [0:N-1][DATA_W-1:0]    wr_row_s;

  logic flush_s;
  logic all_s;
  logic any_s;
  logic row_evt_s;
  logic push_req_s;
  logic push_s;
  logic drop_s;
  logic skew_s;
  logic pop_s;
  logic full_s;

  assign flush_s = start && (state_r != ST_IDLE);

  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int DEPTH = N - 1 - c;
    if (DEPTH == 0) begin : g_direct
      assign al_valid_s[c] = col_valid[c];
      assign al_data_s[c]  = col_data[c];
    end else begin : g_delay
      logic [DEPTH-1:0]  v_r;
      logic [DATA_W-1:0] d_r [DEPTH];

      // Per-column delay line: earlier columns wait longer so row k lines up across all lanes
      always_ff @(posedge clk) begin
        if (!rst_n || flush_s) begin
          v_r <= '0;
          for (int s = 0; s < DEPTH; s++) begin
            d_r[s] <= '0;
          end
        end else begin
          v_r[0] <= col_valid[c];
          d_r[0] <= col_data[c];
          for (int s = 1; s < DEPTH; s++) begin
            v_r[s] <= v_r[s-1];
            d_r[s] <= d_r[s-1];
          end
        end
      end

      assign al_valid_s[c] = v_r[DEPTH-1];
      assign al_data_s[c]  = d_r[DEPTH-1];
    end
  end

`ifdef DRAIN_RELU_EN
  function automatic logic [DATA_W-1:0] relu_f(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? {DATA_W{1'b0}} : x;
  endfunction
`endif

  // Row value written into the FIFO (optionally clamped)
  always_comb begin
    wr_row_s = al_data_s;
`ifdef DRAIN_RELU_EN
    for (int c = 0; c < N; c++) begin
      wr_row_s[c] = relu_f(al_data_s[c]);
    end
`endif
  end

  assign all_s      = &al_valid_s;
  assign any_s      = |al_valid_s;
  assign full_s     = (count_r == (AW+1)'(FIFO_DEPTH));
  assign pop_s      = (count_r != '0) && row_ready;
  // A misaligned row still consumes its slot so later row tags keep matching element indices.
  assign row_evt_s  = (state_r == ST_COLLECT) && any_s && !start;
  assign push_req_s = row_evt_s && all_s;
  assign push_s     = push_req_s && (!full_s || pop_s);
  assign drop_s     = push_req_s && !push_s;
  assign skew_s     = row_evt_s && !all_s;

  // Row FIFO: storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
        tag_r[i] <= '0;
      end
    end else if (flush_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_row_s;
        tag_r[wr_ptr_r] <= cnt_r;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Tile sequencing, row counter and sticky status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      overflow_r <= 1'b0;
      skew_err_r <= 1'b0;
    end else if (start) begin
      state_r    <= ST_COLLECT;
      cnt_r      <= '0;
      overflow_r <= 1'b0;
      skew_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_COLLECT: begin
          if (skew_s) begin
            skew_err_r <= 1'b1;
          end
          if (drop_s) begin
            overflow_r <= 1'b1;
          end
          if (row_evt_s) begin
            if (cnt_r == CNT_W'(ROWS - 1)) begin
              state_r <= ST_FLUSH;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (count_r == '0) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign row_valid = (count_r != '0);
  assign row_data  = mem_r[rd_ptr_r];
  assign row_idx   = tag_r[rd_ptr_r];
  assign tile_done = (state_r == ST_DONE);
  assign overflow  = overflow_r;
  assign skew_err  = skew_err_r;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed self-checking bench for systolic_drain: streaming, overflow, stall/toggle, skew, abort, reset, clamp.
module tb_systolic_drain;

  localparam int N    = 32;
  localparam int DW   = 16;
  localparam int ROWS = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [0:N-1]           col_valid;
  logic [0:N-1][DW-1:0]   col_data;
  logic                   row_valid;
  logic                   row_ready;
  logic [0:N-1][DW-1:0]   row_data;
  logic [4:0]             row_idx;
  logic                   tile_done;
  logic                   overflow;
  logic                   skew_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  systolic_drain #(.N(N), .DATA_W(DW), .ROWS(ROWS), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .col_valid(col_valid), .col_data(col_data),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_idx(row_idx),
    .tile_done(tile_done), .overflow(overflow), .skew_err(skew_err)
  );

  function automatic logic [0:N-1][DW-1:0] exp_row_f(input int k);
    logic [0:N-1][DW-1:0] r;
    for (int c = 0; c < N; c++) r[c] = {8'(c), 8'(k)};
    return r;
  endfunction

  // element k of column c is presented at relative cycle k+c
  task automatic drive_cols(input int t, input int drop_c, input int drop_k);
    for (int c = 0; c < N; c++) begin
      int k;
      k = t - c;
      if (k >= 0 && k < ROWS && !(c == drop_c && k == drop_k)) begin
        col_valid[c] = 1'b1;
        col_data[c]  = {8'(c), 8'(k)};
      end else begin
        col_valid[c] = 1'b0;
        col_data[c]  = '0;
      end
    end
  endtask

  task automatic do_start();
    start     = 1'b1;
    row_ready = 1'b0;
    col_valid = '0;
    col_data  = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; row_ready = 1'b0; col_valid = '0; col_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (row_valid !== 1'b0 || tile_done !== 1'b0 || overflow !== 1'b0 || skew_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags got v=%b d=%b o=%b s=%b want 0000", row_valid, tile_done, overflow, skew_err);
    end
    n_cmp++;
    if (row_data !== '0 || row_idx !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_data got idx=%0d data=%h want 0", row_idx, row_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (row_valid !== 1'b0 || tile_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle got v=%b d=%b want 00", row_valid, tile_done);
    end
  endtask

  task automatic test_stream();
    int exp_k = 0, done_cnt = 0, done_t = -1;
    do_start();
    for (int t = 0; t < 80; t++) begin
      drive_cols(t, -1, -1);
      row_ready = 1'b1;
      if (t == 31 || t == 32) begin
        n_cmp++;
        if (row_valid !== (t == 32)) begin
          n_bad++;
          $display("FAIL stream_first_valid t=%0d got %b want %b", t, row_valid, (t == 32));
        end
      end
      if (row_valid) begin
        n_cmp++;
        if (row_idx !== 5'(exp_k) || row_data !== exp_row_f(exp_k)) begin
          n_bad++;
          $display("FAIL stream_row got idx=%0d data=%h want idx=%0d data=%h", row_idx, row_data, exp_k, exp_row_f(exp_k));
        end
        exp_k++;
      end
      if (tile_done) begin done_cnt++; done_t = t; end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_k !== 32) begin n_bad++; $display("FAIL stream_count got %0d want 32", exp_k); end
    n_cmp++;
    if (done_cnt !== 1 || done_t !== 65) begin
      n_bad++; $display("FAIL stream_done got pulses=%0d at=%0d want 1 at 65", done_cnt, done_t);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL stream_overflow got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    int exp_k = 0, done_cnt = 0, done_t = -1;
    do_start();
    for (int t = 0; t < 96; t++) begin
      drive_cols(t, -1, -1);
      row_ready = (t >= 70);
      if (t == 50 || t == 69) begin
        n_cmp++;
        if (row_valid !== 1'b1 || row_idx !== 5'd0 || row_data !== exp_row_f(0) || overflow !== 1'b1) begin
          n_bad++;
          $display("FAIL ovf_hold t=%0d got v=%b idx=%0d o=%b want v=1 idx=0 o=1", t, row_valid, row_idx, overflow);
        end
      end
      if (row_valid && row_ready) begin
        n_cmp++;
        if (row_idx !== 5'(exp_k) || row_data !== exp_row_f(exp_k)) begin
          n_bad++;
          $display("FAIL ovf_row got idx=%0d data=%h want idx=%0d", row_idx, row_data, exp_k);
        end
        exp_k++;
      end
      if (tile_done) begin done_cnt++; done_t = t; end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_k !== 4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", exp_k); end
    n_cmp++;
    if (done_cnt !== 1 || done_t !== 75) begin
      n_bad++; $display("FAIL ovf_done got pulses=%0d at=%0d want 1 at 75", done_cnt, done_t);
    end
  endtask

  task automatic test_toggle();
    int exp_list[18];
    int n_exp = 0, pi = 0, done_cnt = 0, ek;
    logic prev_stall = 1'b0;
    logic [0:N-1][DW-1:0] prev_data = '0;
    logic [4:0] prev_idx = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (k < 4 || (k % 2 == 0 && k <= 30)) begin exp_list[n_exp] = k; n_exp++; end
    end
    do_start();
    for (int t = 0; t < 120; t++) begin
      drive_cols(t, -1, -1);
      row_ready = (t >= 35 && (t - 35) % 2 == 0);
      if (prev_stall) begin
        n_cmp++;
        if (row_data !== prev_data || row_idx !== prev_idx) begin
          n_bad++;
          $display("FAIL toggle_stable t=%0d got idx=%0d want idx=%0d", t, row_idx, prev_idx);
        end
      end
      if (row_valid && row_ready) begin
        ek = (pi < 18) ? exp_list[pi] : -1;
        n_cmp++;
        if (ek < 0 || row_idx !== 5'(ek) || row_data !== exp_row_f(ek)) begin
          n_bad++;
          $display("FAIL toggle_row got idx=%0d data=%h want idx=%0d", row_idx, row_data, ek);
        end
        pi++;
      end
      prev_stall = row_valid && !row_ready;
      prev_data  = row_data;
      prev_idx   = row_idx;
      if (tile_done) done_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (pi !== 18 || done_cnt !== 1 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL toggle_totals got rows=%0d done=%0d o=%b want 18 1 1", pi, done_cnt, overflow);
    end
  endtask

  task automatic test_skew();
    int exp_k = 0;
    do_start();
    for (int t = 0; t < 90; t++) begin
      drive_cols(t, 5, 2);
      row_ready = 1'b1;
      if (t == 33 || t == 34) begin
        n_cmp++;
        if (skew_err !== (t == 34)) begin
          n_bad++; $display("FAIL skew_flag t=%0d got %b want %b", t, skew_err, (t == 34));
        end
      end
      if (row_valid) begin
        if (exp_k == 2) exp_k = 3;
        n_cmp++;
        if (row_idx !== 5'(exp_k) || row_data !== exp_row_f(exp_k)) begin
          n_bad++;
          $display("FAIL skew_row got idx=%0d data=%h want idx=%0d", row_idx, row_data, exp_k);
        end
        exp_k++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_k !== 32) begin n_bad++; $display("FAIL skew_count got %0d want 32", exp_k); end
    do_start();
    n_cmp++;
    if (skew_err !== 1'b0) begin n_bad++; $display("FAIL skew_clear got %b want 0", skew_err); end
  endtask

  task automatic test_relu();
    logic [DW-1:0] exp0;
`ifdef DRAIN_RELU_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'hFFF0;
`endif
    do_start();
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < N; c++) begin
        col_valid[c] = (t == c);
        col_data[c]  = (t != c) ? 16'h0000 : (c == 0) ? 16'hFFF0 : (c == 1) ? 16'h0010 : {8'(c), 8'h00};
      end
      row_ready = 1'b1;
      if (t == 32) begin
        n_cmp++;
        if (row_valid !== 1'b1 || row_data[0] !== exp0 || row_data[1] !== 16'h0010 || row_data[2] !== 16'h0200) begin
          n_bad++;
          $display("FAIL relu_row got v=%b e0=%h e1=%h e2=%h want 1 %h 0010 0200", row_valid, row_data[0], row_data[1], row_data[2], exp0);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int exp_k = 0, done_cnt = 0, done_t = -1;
    do_start();
    for (int t = 0; t < 41; t++) begin
      drive_cols(t, -1, -1);
      row_ready = 1'b0;
      if (tile_done) done_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (overflow !== 1'b1 || row_valid !== 1'b1) begin
      n_bad++; $display("FAIL abort_pre got o=%b v=%b want 1 1", overflow, row_valid);
    end
    do_start();
    n_cmp++;
    if (row_valid !== 1'b0 || overflow !== 1'b0 || tile_done !== 1'b0) begin
      n_bad++; $display("FAIL abort_flush got v=%b o=%b d=%b want 000", row_valid, overflow, tile_done);
    end
    for (int t = 0; t < 80; t++) begin
      drive_cols(t, -1, -1);
      row_ready = 1'b1;
      if (row_valid) begin
        n_cmp++;
        if (row_idx !== 5'(exp_k) || row_data !== exp_row_f(exp_k) || (exp_k == 0 && t !== 32)) begin
          n_bad++;
          $display("FAIL abort_row t=%0d got idx=%0d data=%h want idx=%0d", t, row_idx, row_data, exp_k);
        end
        exp_k++;
      end
      if (tile_done) begin done_cnt++; done_t = t; end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_k !== 32 || done_cnt !== 1 || done_t !== 65) begin
      n_bad++; $display("FAIL abort_done got rows=%0d pulses=%0d at=%0d want 32 1 65", exp_k, done_cnt, done_t);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    do_start();
    for (int t = 0; t < 40; t++) begin
      drive_cols(t, -1, -1);
      row_ready = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    col_valid = '0;
    col_data  = '0;
    @(negedge clk);
    n_cmp++;
    if (row_valid !== 1'b0 || tile_done !== 1'b0 || overflow !== 1'b0 || skew_err !== 1'b0 ||
        row_data !== '0 || row_idx !== 5'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs got v=%b d=%b o=%b s=%b idx=%0d want all 0", row_valid, tile_done, overflow, skew_err, row_idx);
    end
    rst_n = 1'b1;
    row_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      if (tile_done || row_valid) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midreset_quiet got %0d active cycles want 0", seen); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; row_ready = 1'b0; col_valid = '0; col_data = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_overflow();
    test_toggle();
    test_skew();
    test_relu();
    test_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
